// File: rtl/mbist_alg_scheduler.sv
// Sequences a set of MBIST algorithm controllers one at a time, collecting
// per-algorithm fail flags and guarding each run with a watchdog.
module mbist_alg_scheduler #(
    parameter int NUM_ALG = 4,
    parameter int WD_W    = 20,
    localparam int SEL_W  = (NUM_ALG > 1) ? $clog2(NUM_ALG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bist_start,
    input  logic               bist_abort,
    input  logic [NUM_ALG-1:0] alg_mask,
    input  logic [NUM_ALG-1:0] alg_finish,
    input  logic               alg_fail,
    output logic [NUM_ALG-1:0] alg_en,
    output logic [SEL_W-1:0]   alg_sel,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_ALG-1:0] fail_map,
    output logic               timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [SEL_W-1:0]   LAST_IDX = SEL_W'(NUM_ALG - 1);
    localparam logic [SEL_W-1:0]   SEL_ONE  = SEL_W'(1'b1);
    localparam logic [SEL_W-1:0]   SEL_ZERO = {SEL_W{1'b0}};
    localparam logic [WD_W-1:0]    WD_ONE   = WD_W'(1'b1);
    localparam logic [WD_W-1:0]    WD_ZERO  = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]    WD_MAX   = {WD_W{1'b1}};
    localparam logic [NUM_ALG-1:0] ALG_ZERO = {NUM_ALG{1'b0}};

    function automatic logic [NUM_ALG-1:0] onehot_f(input logic [SEL_W-1:0] i);
        logic [NUM_ALG-1:0] v;
        v = ALG_ZERO;
        for (int k = 0; k < NUM_ALG; k++) begin
            if (i == SEL_W'(k)) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   idx_r, idx_s;
    logic [WD_W-1:0]    wd_r, wd_s;
    logic [NUM_ALG-1:0] mask_r, mask_s;
    logic               fin_hist_r, fin_hist_s;
    logic               rel_cnt_r, rel_cnt_s;
    logic               start_hist_r;
    logic               start_armed_r;
    logic               start_rise_s;
    logic               fin_rise_s;

    logic [NUM_ALG-1:0] en_s;
    logic [SEL_W-1:0]   sel_s;
    logic               busy_s;
    logic               done_s;
    logic               pass_s;
    logic [NUM_ALG-1:0] fail_s;
    logic               timeout_s;

    // A start held high across reset release must be seen low once before an edge counts.
    assign start_rise_s = bist_start & ~start_hist_r & start_armed_r;
    assign fin_rise_s   = alg_finish[idx_r] & ~fin_hist_r;

    // Next-state and next-output decode; abort overrides every other event.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        wd_s       = wd_r;
        mask_s     = mask_r;
        fin_hist_s = fin_hist_r;
        rel_cnt_s  = rel_cnt_r;
        en_s       = alg_en;
        sel_s      = alg_sel;
        busy_s     = busy;
        done_s     = done;
        pass_s     = pass;
        fail_s     = fail_map;
        timeout_s  = timeout;

        if (bist_abort) begin
            state_s = ST_IDLE;
            en_s    = ALG_ZERO;
            busy_s  = 1'b0;
            done_s  = 1'b0;
            pass_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_rise_s) begin
                        state_s   = ST_SELECT;
                        mask_s    = alg_mask;
                        idx_s     = SEL_ZERO;
                        sel_s     = SEL_ZERO;
                        wd_s      = WD_ZERO;
                        fail_s    = ALG_ZERO;
                        timeout_s = 1'b0;
                        done_s    = 1'b0;
                        pass_s    = 1'b0;
                        busy_s    = 1'b1;
                        en_s      = ALG_ZERO;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_SELECT: begin
                    if (mask_r[idx_r]) begin
                        state_s    = ST_RUN;
                        en_s       = onehot_f(idx_r);
                        wd_s       = WD_ZERO;
                        fin_hist_s = alg_finish[idx_r];
                    end else if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = ~|fail_map;
                    end else begin
                        idx_s = idx_r + SEL_ONE;
                        sel_s = idx_r + SEL_ONE;
                    end
                end
                ST_RUN: begin
                    fin_hist_s = alg_finish[idx_r];
                    fail_s     = fail_map | (alg_fail ? onehot_f(idx_r) : ALG_ZERO);
                    // A finish edge coinciding with watchdog expiry is a normal finish.
                    if (fin_rise_s) begin
                        state_s   = ST_RELEASE;
                        en_s      = ALG_ZERO;
                        rel_cnt_s = 1'b0;
                    end else if (wd_r == WD_MAX) begin
                        state_s   = ST_RELEASE;
                        en_s      = ALG_ZERO;
                        rel_cnt_s = 1'b0;
                        fail_s    = fail_map | onehot_f(idx_r);
                        timeout_s = 1'b1;
                    end else begin
                        wd_s = wd_r + WD_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!rel_cnt_r) begin
                        rel_cnt_s = 1'b1;
                    end else if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = ~|fail_map;
                    end else begin
                        state_s = ST_SELECT;
                        idx_s   = idx_r + SEL_ONE;
                        sel_s   = idx_r + SEL_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    en_s    = ALG_ZERO;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                end
            endcase
        end
    end

    // State, edge-history and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= SEL_ZERO;
            wd_r          <= WD_ZERO;
            mask_r        <= ALG_ZERO;
            fin_hist_r    <= 1'b0;
            rel_cnt_r     <= 1'b0;
            start_hist_r  <= 1'b0;
            start_armed_r <= 1'b0;
            alg_en        <= ALG_ZERO;
            alg_sel       <= SEL_ZERO;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_map      <= ALG_ZERO;
            timeout       <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            wd_r          <= wd_s;
            mask_r        <= mask_s;
            fin_hist_r    <= fin_hist_s;
            rel_cnt_r     <= rel_cnt_s;
            start_hist_r  <= bist_start;
            start_armed_r <= start_armed_r | ~bist_start;
            alg_en        <= en_s;
            alg_sel       <= sel_s;
            busy          <= busy_s;
            done          <= done_s;
            pass          <= pass_s;
            fail_map      <= fail_s;
            timeout       <= timeout_s;
        end
    end

endmodule
